// File: rtl/figaro_sha2_512.sv
// FiGaRO-style entropy source (Fibonacci LFSR ^ Galois LFSR) feeding an iterative
// SHA-512 compressor; each 1024-bit block is hashed from the IV and exposed as 16 words.
`timescale 1ns/1ps
module figaro_sha2_512 #(
    parameter logic [31:0] FIB_SEED = 32'hACE10001,
    parameter logic [31:0] GAL_SEED = 32'h12345678
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        ready,
    input  logic [9:0]  ADDR,
    output logic [31:0] DATA_OUT
);

    typedef enum logic [1:0] {COLLECT, HASH, FINAL} state_t;

    localparam logic [7:0][63:0] IV = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    function automatic logic [63:0] k_of(input logic [6:0] t);
        logic [63:0] k;
        case (t)
            7'd0:  k = 64'h428a2f98d728ae22;  7'd1:  k = 64'h7137449123ef65cd;
            7'd2:  k = 64'hb5c0fbcfec4d3b2f;  7'd3:  k = 64'he9b5dba58189dbbc;
            7'd4:  k = 64'h3956c25bf348b538;  7'd5:  k = 64'h59f111f1b605d019;
            7'd6:  k = 64'h923f82a4af194f9b;  7'd7:  k = 64'hab1c5ed5da6d8118;
            7'd8:  k = 64'hd807aa98a3030242;  7'd9:  k = 64'h12835b0145706fbe;
            7'd10: k = 64'h243185be4ee4b28c;  7'd11: k = 64'h550c7dc3d5ffb4e2;
            7'd12: k = 64'h72be5d74f27b896f;  7'd13: k = 64'h80deb1fe3b1696b1;
            7'd14: k = 64'h9bdc06a725c71235;  7'd15: k = 64'hc19bf174cf692694;
            7'd16: k = 64'he49b69c19ef14ad2;  7'd17: k = 64'hefbe4786384f25e3;
            7'd18: k = 64'h0fc19dc68b8cd5b5;  7'd19: k = 64'h240ca1cc77ac9c65;
            7'd20: k = 64'h2de92c6f592b0275;  7'd21: k = 64'h4a7484aa6ea6e483;
            7'd22: k = 64'h5cb0a9dcbd41fbd4;  7'd23: k = 64'h76f988da831153b5;
            7'd24: k = 64'h983e5152ee66dfab;  7'd25: k = 64'ha831c66d2db43210;
            7'd26: k = 64'hb00327c898fb213f;  7'd27: k = 64'hbf597fc7beef0ee4;
            7'd28: k = 64'hc6e00bf33da88fc2;  7'd29: k = 64'hd5a79147930aa725;
            7'd30: k = 64'h06ca6351e003826f;  7'd31: k = 64'h142929670a0e6e70;
            7'd32: k = 64'h27b70a8546d22ffc;  7'd33: k = 64'h2e1b21385c26c926;
            7'd34: k = 64'h4d2c6dfc5ac42aed;  7'd35: k = 64'h53380d139d95b3df;
            7'd36: k = 64'h650a73548baf63de;  7'd37: k = 64'h766a0abb3c77b2a8;
            7'd38: k = 64'h81c2c92e47edaee6;  7'd39: k = 64'h92722c851482353b;
            7'd40: k = 64'ha2bfe8a14cf10364;  7'd41: k = 64'ha81a664bbc423001;
            7'd42: k = 64'hc24b8b70d0f89791;  7'd43: k = 64'hc76c51a30654be30;
            7'd44: k = 64'hd192e819d6ef5218;  7'd45: k = 64'hd69906245565a910;
            7'd46: k = 64'hf40e35855771202a;  7'd47: k = 64'h106aa07032bbd1b8;
            7'd48: k = 64'h19a4c116b8d2d0c8;  7'd49: k = 64'h1e376c085141ab53;
            7'd50: k = 64'h2748774cdf8eeb99;  7'd51: k = 64'h34b0bcb5e19b48a8;
            7'd52: k = 64'h391c0cb3c5c95a63;  7'd53: k = 64'h4ed8aa4ae3418acb;
            7'd54: k = 64'h5b9cca4f7763e373;  7'd55: k = 64'h682e6ff3d6b2b8a3;
            7'd56: k = 64'h748f82ee5defb2fc;  7'd57: k = 64'h78a5636f43172f60;
            7'd58: k = 64'h84c87814a1f0ab72;  7'd59: k = 64'h8cc702081a6439ec;
            7'd60: k = 64'h90befffa23631e28;  7'd61: k = 64'ha4506cebde82bde9;
            7'd62: k = 64'hbef9a3f7b2c67915;  7'd63: k = 64'hc67178f2e372532b;
            7'd64: k = 64'hca273eceea26619c;  7'd65: k = 64'hd186b8c721c0c207;
            7'd66: k = 64'heada7dd6cde0eb1e;  7'd67: k = 64'hf57d4f7fee6ed178;
            7'd68: k = 64'h06f067aa72176fba;  7'd69: k = 64'h0a637dc5a2c898a6;
            7'd70: k = 64'h113f9804bef90dae;  7'd71: k = 64'h1b710b35131c471b;
            7'd72: k = 64'h28db77f523047d84;  7'd73: k = 64'h32caab7b40c72493;
            7'd74: k = 64'h3c9ebe0a15c9bebc;  7'd75: k = 64'h431d67c49c100d4c;
            7'd76: k = 64'h4cc5d4becb3e42b6;  7'd77: k = 64'h597f299cfc657e2a;
            7'd78: k = 64'h5fcb6fab3ad6faec;  7'd79: k = 64'h6c44198c4a475817;
            default: k = 64'h0;
        endcase
        return k;
    endfunction

    function automatic logic [63:0] big_sigma0(input logic [63:0] x);
        return {x[27:0], x[63:28]} ^ {x[33:0], x[63:34]} ^ {x[38:0], x[63:39]};
    endfunction

    function automatic logic [63:0] big_sigma1(input logic [63:0] x);
        return {x[13:0], x[63:14]} ^ {x[17:0], x[63:18]} ^ {x[40:0], x[63:41]};
    endfunction

    function automatic logic [63:0] small_sigma0(input logic [63:0] x);
        return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ {7'b0, x[63:7]};
    endfunction

    function automatic logic [63:0] small_sigma1(input logic [63:0] x);
        return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ {6'b0, x[63:6]};
    endfunction

    state_t            state_q, state_d;
    logic [31:0]       fib_q, fib_d;
    logic [31:0]       gal_q, gal_d;
    logic [9:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        round_q, round_d;
    logic [1023:0]     msg_q, msg_d;
    logic [7:0][63:0]  work_q, work_d;
    logic [7:0][63:0]  digest_q, digest_d;
    logic              ready_q, ready_d;

    logic              ent_bit;
    logic [63:0]       a, b, c, d, e, f, g, h;
    logic [63:0]       w0, w1, w9, w14, w_next;
    logic [63:0]       t1, t2;
    logic [15:0][31:0] digest_words;

    assign ent_bit = fib_q[31] ^ gal_q[0];

    assign {a, b, c, d, e, f, g, h} = work_q;

    // msg_q doubles as the schedule window during HASH: word i sits at bits [1023-64*i -: 64].
    assign w0  = msg_q[1023:960];
    assign w1  = msg_q[959:896];
    assign w9  = msg_q[447:384];
    assign w14 = msg_q[127:64];

    assign w_next = small_sigma1(w14) + w9 + small_sigma0(w1) + w0;
    assign t1     = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + k_of(round_q) + w0;
    assign t2     = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        round_d   = round_q;
        msg_d     = msg_q;
        work_d    = work_q;
        digest_d  = digest_q;
        ready_d   = ready_q;
        fib_d     = {fib_q[30:0], fib_q[31] ^ fib_q[21] ^ fib_q[1] ^ fib_q[0]};
        gal_d     = (gal_q >> 1) ^ (gal_q[0] ? 32'h80200003 : 32'h0);

        if (enable) begin
            case (state_q)
                COLLECT: begin
                    msg_d = {msg_q[1022:0], ent_bit};
                    if (bit_cnt_q == 10'd1023) begin
                        bit_cnt_d = '0;
                        round_d   = '0;
                        work_d    = IV;
                        state_d   = HASH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 10'd1;
                    end
                end
                HASH: begin
                    work_d = {t1 + t2, a, b, c, d + t1, e, f, g};
                    msg_d  = {msg_q[959:0], w_next};
                    if (round_q == 7'd79) begin
                        round_d = '0;
                        state_d = FINAL;
                    end else begin
                        round_d = round_q + 7'd1;
                    end
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        digest_d[i] = IV[i] + work_q[i];
                    end
                    ready_d   = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = COLLECT;
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= COLLECT;
            fib_q     <= FIB_SEED;
            gal_q     <= GAL_SEED;
            bit_cnt_q <= '0;
            round_q   <= '0;
            msg_q     <= '0;
            work_q    <= '0;
            digest_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            fib_q     <= fib_d;
            gal_q     <= gal_d;
            bit_cnt_q <= bit_cnt_d;
            round_q   <= round_d;
            msg_q     <= msg_d;
            work_q    <= work_d;
            digest_q  <= digest_d;
            ready_q   <= ready_d;
        end
    end

    assign ready        = ready_q;
    assign digest_words = digest_q;

    always_comb begin
        DATA_OUT = '0;
        if (ADDR[9:4] == 6'd0) begin
            DATA_OUT = digest_words[4'd15 - ADDR[3:0]];
        end
    end

endmodule

// File: tb/tb_figaro_sha2_512.sv
// Self-checking bench for figaro_sha2_512: cycle-accurate LFSR/bit-collection model
// plus an independent full-schedule SHA-512 compression used as the golden digest.
`timescale 1ns/1ps
module tb_figaro_sha2_512;

    localparam logic [31:0] FIB_SEED = 32'hACE10001;
    localparam logic [31:0] GAL_SEED = 32'h12345678;

    localparam logic [63:0] K_TAB [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    localparam logic [63:0] H_IV [8] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    localparam logic [511:0] ABC_DIGEST =
        512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        ready;
    logic [9:0]  ADDR;
    logic [31:0] DATA_OUT;

    always #50 clk = ~clk;

    figaro_sha2_512 #(.FIB_SEED(FIB_SEED), .GAL_SEED(GAL_SEED)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .ready    (ready),
        .ADDR     (ADDR),
        .DATA_OUT (DATA_OUT)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0]   m_fib;
    logic [31:0]   m_gal;
    logic [1023:0] m_msg;
    int            m_phase;
    logic [511:0]  exp_digest;
    logic          exp_ready;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [511:0] sha512_block(input logic [1023:0] blk);
        logic [63:0]  w [80];
        logic [63:0]  v [8];
        logic [63:0]  t1, t2, s0, s1, ch, mj;
        logic [511:0] res;
        for (int t = 0; t < 16; t++) w[t] = blk[1023 - 64*t -: 64];
        for (int t = 16; t < 80; t++) begin
            s0 = rotr(w[t-15], 1) ^ rotr(w[t-15], 8) ^ (w[t-15] >> 7);
            s1 = rotr(w[t-2], 19) ^ rotr(w[t-2], 61) ^ (w[t-2] >> 6);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = H_IV[i];
        for (int t = 0; t < 80; t++) begin
            s1 = rotr(v[4], 14) ^ rotr(v[4], 18) ^ rotr(v[4], 41);
            ch = (v[4] & v[5]) ^ (~v[4] & v[6]);
            t1 = v[7] + s1 + ch + K_TAB[t] + w[t];
            s0 = rotr(v[0], 28) ^ rotr(v[0], 34) ^ rotr(v[0], 39);
            mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            t2 = s0 + mj;
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[511 - 64*i -: 64] = H_IV[i] + v[i];
        return res;
    endfunction

    function automatic logic [31:0] exp_word(input logic [9:0] a);
        logic [511:0] tmp;
        if (a[9:4] != 6'd0) return 32'h0;
        tmp = exp_digest << (32 * int'(a[3:0]));
        return tmp[511:480];
    endfunction

    // Advance the reference by one clock edge, then sample the DUT on the falling edge.
    task automatic tick(input logic en, input logic rst);
        logic ebit;
        enable = en;
        reset  = rst;
        if (rst) begin
            m_fib      = FIB_SEED;
            m_gal      = GAL_SEED;
            m_msg      = '0;
            m_phase    = 0;
            exp_ready  = 1'b0;
            exp_digest = '0;
        end else begin
            ebit = m_fib[31] ^ m_gal[0];
            if (en) begin
                if (m_phase < 1024) m_msg = {m_msg[1022:0], ebit};
                m_phase++;
                if (m_phase == 1105) begin
                    exp_digest = sha512_block(m_msg);
                    exp_ready  = 1'b1;
                    m_phase    = 0;
                end
            end
            m_fib = {m_fib[30:0], m_fib[31] ^ m_fib[21] ^ m_fib[1] ^ m_fib[0]};
            m_gal = (m_gal >> 1) ^ (m_gal[0] ? 32'h80200003 : 32'h0);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check("ready", ready, exp_ready);
        check("data_out_running", DATA_OUT, exp_word(ADDR));
        ADDR = 10'(cyc % 16);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            ADDR = 10'(i);
            #1;
            check($sformatf("%s_word%0d", tag, i), DATA_OUT, exp_word(10'(i)));
        end
        ADDR = 10'd0;
    endtask

    initial begin
        #(100 * 20000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1023:0] abc_blk;
        logic [511:0]  blk1;

        reset  = 1'b1;
        enable = 1'b1;
        ADDR   = 10'd0;
        @(negedge clk);

        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        check_all("reset");
        check("first_bit", m_fib[31] ^ m_gal[0], 1'b1);

        abc_blk            = '0;
        abc_blk[1023:992]  = 32'h61626380;
        abc_blk[7:0]       = 8'h18;
        check("model_kat_abc", sha512_block(abc_blk), ABC_DIGEST);

        repeat (1104) tick(1'b1, 1'b0);
        check("ready_edge1104", ready, 1'b0);
        tick(1'b1, 1'b0);
        check("ready_edge1105", ready, 1'b1);
        check_all("block1");
        blk1 = exp_digest;

        ADDR = 10'h010; #1; check("addr_010", DATA_OUT, 32'h0);
        ADDR = 10'h3FF; #1; check("addr_3ff", DATA_OUT, 32'h0);
        ADDR = 10'h000; #1; check("addr_0",   DATA_OUT, blk1[511:480]);
        ADDR = 10'h00F; #1; check("addr_15",  DATA_OUT, blk1[31:0]);
        ADDR = 10'h000;

        repeat (1105) tick(1'b1, 1'b0);
        check("ready_block2", ready, 1'b1);
        check_all("block2");

        repeat (1050) tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        check("ready_after_reset", ready, 1'b0);
        check_all("mid_hash_reset");

        repeat (1030) tick(1'b1, 1'b0);
        repeat (50)   tick(1'b0, 1'b0);
        repeat (74)   tick(1'b1, 1'b0);
        check("ready_edge1154", ready, 1'b0);
        tick(1'b1, 1'b0);
        check("ready_edge1155", ready, 1'b1);
        check_all("paused");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
